// File: rtl/tcp_session_wd_pkg.sv
// tcp_session_wd_pkg: shared state encoding, stat width and default parameters for the deadlock watchdog.
package tcp_session_wd_pkg;
    localparam int DEF_NUM_AXIS  = 5;
    localparam int DEF_TIMEOUT_W = 16;
    localparam int STAT_W        = 16;
    typedef enum logic [2:0] {IDLE, WATCH, COUNT, DEADLOCK, REPORTED} wd_state_e;
endpackage

// File: rtl/tcp_session_wd_timer.sv
// tcp_session_wd_timer: blocked-cycle counter and threshold compare producing a one-cycle expire strobe.
module tcp_session_wd_timer
    import tcp_session_wd_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    input  logic                 sample,
    input  logic                 watch,
    input  logic                 count,
    input  logic                 blk,
    output logic                 expire,
    output logic [TIMEOUT_W-1:0] thr_eff
);
    logic [TIMEOUT_W-1:0] thr, cnt, thr_cfg;
    // cnt tops out at thr-1, so the largest threshold never overflows it
    always_comb begin
        thr_cfg = (timeout_cfg == '0) ? TIMEOUT_W'(1) : timeout_cfg;
        thr_eff = sample ? thr_cfg : thr;
        expire  = blk & (watch ? (thr_cfg == TIMEOUT_W'(1)) : count & (cnt == thr - TIMEOUT_W'(1)));
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            thr <= TIMEOUT_W'(1);
            cnt <= '0;
        end else begin
            if (sample) thr <= thr_cfg;
            cnt <= (blk & ~expire) ? (watch ? TIMEOUT_W'(1) : count ? cnt + TIMEOUT_W'(1) : '0) : '0;
        end
    end
endmodule

// File: rtl/tcp_session_deadlock_watchdog.sv
// tcp_session_deadlock_watchdog: flags a monitored instance blocked for too many consecutive cycles and reports it.
// Optional TCP_SESSION_WD_STATS_EN adds a saturating deadlock counter output stat_deadlocks.
module tcp_session_deadlock_watchdog
    import tcp_session_wd_pkg::*;
#(
    parameter int NUM_AXIS  = DEF_NUM_AXIS,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    input  logic [NUM_AXIS-1:0]  axis_block_sigs,
    input  logic                 inst_idle_sigs,
    input  logic                 inst_block_sigs,
    input  logic                 clear,
    output logic                 block,
    output logic                 report_valid,
    input  logic                 report_ready,
    output logic [NUM_AXIS-1:0]  report_mask,
    output logic [TIMEOUT_W-1:0] report_cycles
`ifdef TCP_SESSION_WD_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_deadlocks
`endif
);
    wd_state_e state, nxt;
    logic blk, watch, count, expire, enter, held;
    logic [NUM_AXIS-1:0] mask_nxt;
    logic [TIMEOUT_W-1:0] thr_eff;
    assign blk   = ~inst_idle_sigs & (|axis_block_sigs | inst_block_sigs);
    assign watch = enable & (state == WATCH);
    assign count = enable & (state == COUNT);
    assign held  = (state == DEADLOCK) | (state == REPORTED);
    assign enter = (nxt == DEADLOCK) & (state != DEADLOCK);
    tcp_session_wd_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .timeout_cfg (timeout_cfg),
        .sample      ((state == IDLE) | (state == WATCH)),
        .watch       (watch),
        .count       (count),
        .blk         (blk),
        .expire      (expire),
        .thr_eff     (thr_eff)
    );
    // clear outranks the report handshake; disable outranks everything
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:         nxt = WATCH;
            WATCH, COUNT: nxt = expire ? DEADLOCK : blk ? COUNT : WATCH;
            DEADLOCK:     nxt = clear ? WATCH : report_ready ? REPORTED : DEADLOCK;
            REPORTED:     nxt = clear ? WATCH : REPORTED;
            default:      nxt = IDLE;
        endcase
        if (!enable) nxt = IDLE;
        mask_nxt = !enable ? '0 :
                   (watch & blk) ? axis_block_sigs :
                   (count & blk) ? report_mask | axis_block_sigs :
                   (held & ~clear) ? report_mask : '0;
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            block         <= 1'b0;
            report_valid  <= 1'b0;
            report_mask   <= '0;
            report_cycles <= '0;
        end else begin
            state        <= nxt;
            block        <= (nxt == DEADLOCK) | (nxt == REPORTED);
            report_valid <= (nxt == DEADLOCK);
            report_mask  <= mask_nxt;
            if (enter) report_cycles <= thr_eff;
        end
    end
`ifdef TCP_SESSION_WD_STATS_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) stat_deadlocks <= '0;
        else if (enter && stat_deadlocks != '1) stat_deadlocks <= stat_deadlocks + STAT_W'(1);
    end
`endif
endmodule

// File: tb/tb_tcp_session_deadlock_watchdog.sv
// tb_tcp_session_deadlock_watchdog: directed and random stimulus checked against a streak-counting reference model.
module tb_tcp_session_deadlock_watchdog;
    localparam int N  = 5;
    localparam int TW = 16;
    logic ap_clk = 0, ap_rst_n = 0, enable = 0, inst_idle_sigs = 0, inst_block_sigs = 0, clear = 0, report_ready = 0;
    logic [TW-1:0] timeout_cfg = '0;
    logic [N-1:0] axis_block_sigs = '0;
    logic block, report_valid;
    logic [N-1:0] report_mask;
    logic [TW-1:0] report_cycles;
`ifdef TCP_SESSION_WD_STATS_EN
    logic [15:0] stat_deadlocks;
`endif
    int errors = 0, checks = 0;
    bit m_active, m_dead, m_rep;
    int m_streak, m_thr, m_rc, m_stats;
    logic [N-1:0] m_mask;

    always #5 ap_clk = ~ap_clk;

    tcp_session_deadlock_watchdog #(.NUM_AXIS(N), .TIMEOUT_W(TW)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .enable          (enable),
        .timeout_cfg     (timeout_cfg),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .clear           (clear),
        .block           (block),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_mask     (report_mask),
        .report_cycles   (report_cycles)
`ifdef TCP_SESSION_WD_STATS_EN
        ,
        .stat_deadlocks  (stat_deadlocks)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_dead = 0; m_rep = 0; m_streak = 0; m_thr = 1; m_rc = 0; m_stats = 0; m_mask = '0;
    endfunction

    // a deadlock is a run of thr consecutive blocked edges while armed and not already latched
    function automatic void model_step();
        bit b = !inst_idle_sigs && ((|axis_block_sigs) || inst_block_sigs);
        int thr_now = (timeout_cfg == 0) ? 1 : int'(timeout_cfg);
        if (!enable) begin
            m_active = 0; m_dead = 0; m_rep = 0; m_streak = 0; m_mask = '0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_dead) begin
            if (clear) begin m_dead = 0; m_rep = 0; m_mask = '0; end
            else if (!m_rep && report_ready) m_rep = 1;
        end else begin
            if (m_streak == 0) m_thr = thr_now;
            if (b) begin
                m_mask = (m_streak == 0) ? axis_block_sigs : (m_mask | axis_block_sigs);
                m_streak++;
                if (m_streak >= m_thr) begin
                    m_dead = 1; m_rc = m_thr; m_streak = 0;
                    if (m_stats < 65535) m_stats++;
                end
            end else begin
                m_streak = 0; m_mask = '0;
            end
        end
    endfunction

    task automatic check_all();
        chk("block", block, m_dead);
        chk("report_valid", report_valid, m_dead && !m_rep);
        chk("report_mask", report_mask, m_mask);
        chk("report_cycles", report_cycles, m_rc);
`ifdef TCP_SESSION_WD_STATS_EN
        chk("stat_deadlocks", stat_deadlocks, m_stats);
`endif
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_step();
        @(negedge ap_clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge ap_clk);
        check_all();
        ap_rst_n = 1;
        // held single-channel block, threshold 4
        enable = 1; timeout_cfg = 4;
        tick();
        axis_block_sigs = 5'b00100;
        repeat (3) tick();
        chk("t4_not_yet", block, 0);
        tick();
        chk("t4_block", block, 1);
        chk("t4_mask", report_mask, 5'b00100);
        chk("t4_cycles", report_cycles, 4);
        // stalled handshake, sticky block, then clear
        axis_block_sigs = '0;
        repeat (5) tick();
        chk("stall_valid", report_valid, 1);
        chk("stall_mask", report_mask, 5'b00100);
        report_ready = 1;
        tick();
        report_ready = 0;
        chk("reported_valid", report_valid, 0);
        chk("reported_block", block, 1);
        repeat (2) tick();
        clear = 1;
        tick();
        clear = 0;
        chk("clear_block", block, 0);
        // interrupted episodes never reach the threshold
        axis_block_sigs = 5'b00100;
        repeat (3) tick();
        chk("ep_mask", report_mask, 5'b00100);
        axis_block_sigs = '0;
        tick();
        chk("ep_mask_zero", report_mask, 0);
        axis_block_sigs = 5'b00010;
        repeat (3) tick();
        chk("ep_no_block", block, 0);
        axis_block_sigs = '0;
        tick();
        // zero timeout behaves as one
        timeout_cfg = 0;
        tick();
        inst_block_sigs = 1;
        tick();
        inst_block_sigs = 0;
        chk("t0_block", block, 1);
        chk("t0_cycles", report_cycles, 1);
        // clear with simultaneous ready
        clear = 1; report_ready = 1;
        tick();
        clear = 0; report_ready = 0;
        chk("clr_rdy_block", block, 0);
        chk("clr_rdy_valid", report_valid, 0);
        // idle instance suppresses blocking
        timeout_cfg = 8; inst_idle_sigs = 1; axis_block_sigs = 5'b11111;
        repeat (100) tick();
        chk("idle_block", block, 0);
        inst_idle_sigs = 0; axis_block_sigs = '0;
        // reset mid-episode
        timeout_cfg = 6; axis_block_sigs = 5'b00001;
        repeat (3) tick();
        ap_rst_n = 0;
        #1;
        model_reset();
        check_all();
        axis_block_sigs = '0;
        @(negedge ap_clk);
        ap_rst_n = 1;
        repeat (10) tick();
        chk("post_rst_valid", report_valid, 0);
        // disable drops a deadlock
        timeout_cfg = 1; axis_block_sigs = 5'b10000;
        repeat (2) tick();
        chk("dis_pre", block, 1);
        enable = 0;
        tick();
        chk("dis_block", block, 0);
        axis_block_sigs = '0;
        // largest threshold
        enable = 1; timeout_cfg = 16'hFFFF;
        tick();
        axis_block_sigs = 5'b01000;
        repeat (65534) tick();
        chk("max_not_yet", block, 0);
        tick();
        chk("max_block", block, 1);
        chk("max_cycles", report_cycles, 16'hFFFF);
        axis_block_sigs = '0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 49) != 0);
            timeout_cfg = TW'($urandom_range(0, 5));
            inst_idle_sigs = ($urandom_range(0, 9) == 0);
            axis_block_sigs = ($urandom_range(0, 3) != 0) ? N'($urandom) : '0;
            inst_block_sigs = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 19) == 0);
            report_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tcp_session_deadlock_watchdog.md
TCP_SESSION_DEADLOCK_WATCHDOG -- requirements
Module: tcp_session_deadlock_watchdog

Interface
REQ-001 Parameter NUM_AXIS, default 5, number of monitored AXIS channel block signals.
REQ-002 Parameter TIMEOUT_W, default 16, width of the timeout threshold and blocked-cycle counter.
REQ-003 ap_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  watchdog armed when high.
REQ-006 timeout_cfg  input  TIMEOUT_W  consecutive blocked cycles declaring deadlock; sampled only in IDLE/WATCH.
REQ-007 axis_block_sigs  input  NUM_AXIS  per-channel AXIS blocked flags.
REQ-008 inst_idle_sigs  input  1  monitored instance idle; suppresses blocking.
REQ-009 inst_block_sigs  input  1  monitored instance internally blocked.
REQ-010 clear  input  1  one-cycle pulse; acknowledges deadlock and rearms.
REQ-011 block  output  1  registered deadlock flag.
REQ-012 report_valid / report_ready  output / input  1 / 1  report handshake.
REQ-013 report_mask  output  NUM_AXIS  channels seen blocked during the offending episode.
REQ-014 report_cycles  output  TIMEOUT_W  effective threshold in force when deadlock was declared.

Function
REQ-015 blk_now = ~inst_idle_sigs & (|axis_block_sigs | inst_block_sigs).
REQ-016 States SHALL be IDLE, WATCH, COUNT, DEADLOCK, REPORTED.
REQ-017 IDLE->WATCH when enable=1; any state->IDLE next cycle when enable=0, dropping report_valid and block and zeroing counter and mask.
REQ-018 WATCH: latch thr = max(timeout_cfg,1); blk_now=1 -> COUNT with cnt=1, mask=axis_block_sigs.
REQ-019 COUNT: blk_now=1 -> cnt+1, mask |= axis_block_sigs; blk_now=0 -> WATCH, cnt=0, mask=0.
REQ-020 COUNT->DEADLOCK when blk_now=1 and cnt==thr-1; thr=1 goes WATCH->DEADLOCK directly on first blocked cycle.
REQ-021 Latency: with blk_now high from edge k, block=1 visible after edge k+thr-1... precisely, block is high after the thr-th consecutive blocked-sampling edge.
REQ-022 DEADLOCK: block=1, report_valid=1, report_mask/report_cycles frozen; report_valid&report_ready -> REPORTED.
REQ-023 REPORTED: block=1, report_valid=0; stays until clear or enable=0.
REQ-024 clear in DEADLOCK/REPORTED -> WATCH next cycle, block=0; clear wins over simultaneous report handshake (no report completed); clear ignored in IDLE/WATCH/COUNT.
REQ-025 blk_now deasserting in DEADLOCK/REPORTED SHALL NOT clear block (sticky until clear).
REQ-026 Report outputs SHALL stay stable while report_valid=1 and report_ready=0.
REQ-027 cnt SHALL never wrap; thr = 2^TIMEOUT_W-1 reachable without overflow.

Reset
REQ-028 On ap_rst_n=0: state=IDLE, block=0, report_valid=0, report_mask=0, report_cycles=0, cnt=0, thr=1, stat counter=0.
REQ-029 Reset mid-episode SHALL discard it; no report after release.

Configuration
REQ-030 Macro TCP_SESSION_WD_STATS_EN defined: output stat_deadlocks (16 bit) increments per DEADLOCK entry, saturating at 0xFFFF, cleared only by reset; undefined: port and counter absent, behaviour otherwise identical.

Structure
REQ-031 Package tcp_session_wd_pkg SHALL hold the state enum, stat width constant and default parameter values.
REQ-032 Sub-module tcp_session_wd_timer SHALL hold cnt/thr compare logic and output a one-cycle expire strobe; FSM stays in the top.

Verification
REQ-033 timeout_cfg=4, axis_block_sigs=5'b00100 held -> block=1 after 4th blocked edge, report_mask=00100, report_cycles=4.
REQ-034 timeout_cfg=4, blocked 3 cycles, 1 free, blocked 3 -> block stays 0, mask returns to 0 in WATCH.
REQ-035 timeout_cfg=0, inst_block_sigs pulse 1 cycle -> DEADLOCK next edge, report_cycles=1.
REQ-036 DEADLOCK with report_ready=0 for 5 cycles then 1 -> outputs stable, REPORTED, block=1; clear -> block=0 next edge.
REQ-037 inst_idle_sigs=1 with axis_block_sigs=5'b11111 for 100 cycles, timeout 8 -> block never asserts.
REQ-038 clear and report_ready together in DEADLOCK -> WATCH, no REPORTED state; ap_rst_n pulse in COUNT -> all outputs 0.
